// File: rtl/gpio_btn_events.sv
// Button/switch event generator: turns debounced GPIO levels into single-cycle
// press/release/auto-repeat pulses and a latched switch-change event that the
// consumer acknowledges.
module gpio_btn_events #(
  parameter int unsigned CLK_FREQUENCY_HZ   = 50_000_000,
  parameter int unsigned TICK_HZ            = 1000,
  parameter int unsigned REPEAT_DELAY_TICKS = 500,
  parameter int unsigned REPEAT_RATE_TICKS  = 100,
  parameter int unsigned SIMULATE           = 0,
  parameter int unsigned SIMULATE_TICK_CNT  = 4
) (
  input  logic        clk,
  input  logic        sysreset_n,
  input  logic [5:0]  pbtn_db,
  input  logic [15:0] swtch_db,
  input  logic        sw_ack,
  output logic [5:0]  btn_press,
  output logic [5:0]  btn_release,
  output logic [5:0]  btn_repeat,
  output logic        sw_changed,
  output logic [15:0] sw_snapshot,
  output logic        sw_event_pending
);

  localparam int unsigned TickTop =
      (SIMULATE != 0) ? SIMULATE_TICK_CNT : (CLK_FREQUENCY_HZ / TICK_HZ) - 1;
  localparam logic [15:0] DelayLast = 16'(REPEAT_DELAY_TICKS - 1);
  localparam logic [15:0] RateLast  = 16'(REPEAT_RATE_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} btn_state_e;

  logic [31:0] presc_q, presc_d;
  logic        tick;

  logic        primed_q;
  logic [5:0]  prev_pbtn_q;
  logic [15:0] prev_sw_q;

  logic [5:0]  press_q, press_d;
  logic [5:0]  release_q, release_d;
  logic [5:0]  repeat_q, repeat_d;
  logic        changed_q, changed_d;
  logic [15:0] snapshot_q, snapshot_d;
  logic        pending_q, pending_d;

  // Bit 0 is the CPU reset button and never auto-repeats, so it has no FSM.
  btn_state_e  state_q [1:5];
  btn_state_e  state_d [1:5];
  logic [15:0] hcnt_q  [1:5];
  logic [15:0] hcnt_d  [1:5];

  // Free-running prescaler; tick marks the last count before the wrap.
  always_comb begin
    tick    = (presc_q == TickTop);
    presc_d = tick ? 32'd0 : presc_q + 32'd1;
  end

  // Edge detect, per-button repeat FSMs and switch-event next state.
  always_comb begin
    // Nothing fires on the priming cycle: prev_* are not yet valid.
    press_d   = primed_q ? (pbtn_db & ~prev_pbtn_q) : 6'd0;
    release_d = primed_q ? (~pbtn_db & prev_pbtn_q) : 6'd0;
    repeat_d  = 6'd0;

    for (int i = 1; i <= 5; i++) begin
      state_d[i] = state_q[i];
      hcnt_d[i]  = hcnt_q[i];
      if (release_d[i]) begin
        // Release beats a repeat due on the same edge.
        state_d[i] = StIdle;
        hcnt_d[i]  = 16'd0;
      end else if (press_d[i]) begin
        state_d[i] = StDelay;
        hcnt_d[i]  = 16'd0;
      end else if (tick) begin
        case (state_q[i])
          StDelay: begin
            if (hcnt_q[i] == DelayLast) begin
              repeat_d[i] = 1'b1;
              hcnt_d[i]   = 16'd0;
              state_d[i]  = StRepeat;
            end else begin
              hcnt_d[i] = hcnt_q[i] + 16'd1;
            end
          end
          StRepeat: begin
            if (hcnt_q[i] == RateLast) begin
              repeat_d[i] = 1'b1;
              hcnt_d[i]   = 16'd0;
            end else begin
              hcnt_d[i] = hcnt_q[i] + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end

    changed_d  = primed_q && (swtch_db != prev_sw_q);
    snapshot_d = (!primed_q || changed_d) ? swtch_db : snapshot_q;
    // A new change outranks an acknowledge in the same cycle.
    if (changed_d) begin
      pending_d = 1'b1;
    end else if (sw_ack) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      presc_q     <= 32'd0;
      primed_q    <= 1'b0;
      prev_pbtn_q <= 6'd0;
      prev_sw_q   <= 16'd0;
      press_q     <= 6'd0;
      release_q   <= 6'd0;
      repeat_q    <= 6'd0;
      changed_q   <= 1'b0;
      snapshot_q  <= 16'd0;
      pending_q   <= 1'b0;
      for (int i = 1; i <= 5; i++) begin
        state_q[i] <= StIdle;
        hcnt_q[i]  <= 16'd0;
      end
    end else begin
      presc_q     <= presc_d;
      primed_q    <= 1'b1;
      prev_pbtn_q <= pbtn_db;
      prev_sw_q   <= swtch_db;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      changed_q   <= changed_d;
      snapshot_q  <= snapshot_d;
      pending_q   <= pending_d;
      for (int i = 1; i <= 5; i++) begin
        state_q[i] <= state_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  assign btn_press        = press_q;
  assign btn_release      = release_q;
  assign btn_repeat       = repeat_q;
  assign sw_changed       = changed_q;
  assign sw_snapshot      = snapshot_q;
  assign sw_event_pending = pending_q;

endmodule

// File: tb/tb_gpio_btn_events.sv
// Directed bench for gpio_btn_events with a 5-clock tick, 3-tick delay and
// 2-tick repeat rate. Inputs change and outputs are sampled on the falling edge.
module tb_gpio_btn_events;

  logic        clk = 1'b0;
  logic        sysreset_n = 1'b1;
  logic [5:0]  pbtn_db = 6'h04;
  logic [15:0] swtch_db = 16'hA5A5;
  logic        sw_ack = 1'b0;
  logic [5:0]  btn_press, btn_release, btn_repeat;
  logic        sw_changed, sw_event_pending;
  logic [15:0] sw_snapshot;

  int n_assert = 0;
  int n_fail   = 0;
  int rep_cnt, extra, acc, r1;
  int rep_pos [3];

  gpio_btn_events #(
    .CLK_FREQUENCY_HZ  (50_000_000),
    .TICK_HZ           (1000),
    .REPEAT_DELAY_TICKS(3),
    .REPEAT_RATE_TICKS (2),
    .SIMULATE          (1),
    .SIMULATE_TICK_CNT (4)
  ) dut (
    .clk             (clk),
    .sysreset_n      (sysreset_n),
    .pbtn_db         (pbtn_db),
    .swtch_db        (swtch_db),
    .sw_ack          (sw_ack),
    .btn_press       (btn_press),
    .btn_release     (btn_release),
    .btn_repeat      (btn_repeat),
    .sw_changed      (sw_changed),
    .sw_snapshot     (sw_snapshot),
    .sw_event_pending(sw_event_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Reset with button 2 held and switches at A5A5.
    #1 sysreset_n = 1'b0;
    cyc();
    cyc();
    chk("rst_press", btn_press, 6'h00);
    chk("rst_release", btn_release, 6'h00);
    chk("rst_repeat", btn_repeat, 6'h00);
    chk("rst_changed", sw_changed, 1'b0);
    chk("rst_pending", sw_event_pending, 1'b0);
    chk("rst_snapshot", sw_snapshot, 16'h0000);

    // Priming.
    sysreset_n = 1'b1;
    cyc();
    chk("prime_press", btn_press, 6'h00);
    chk("prime_changed", sw_changed, 1'b0);
    chk("prime_snapshot", sw_snapshot, 16'hA5A5);
    cyc();
    chk("prime_press2", btn_press, 6'h00);
    chk("prime_changed2", sw_changed, 1'b0);
    pbtn_db = 6'h00;
    cyc();
    chk("held_release", btn_release, 6'h04);
    cyc();
    chk("held_release_single", btn_release, 6'h00);

    // Press/repeat timing on button 1, held 40 clocks.
    pbtn_db = 6'h02;
    rep_cnt = 0;
    rep_pos = '{0, 0, 0};
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 1) chk("b1_press", btn_press, 6'h02);
      if (i == 2) chk("b1_press_single", btn_press, 6'h00);
      if (btn_repeat[1]) begin
        if (rep_cnt < 3) rep_pos[rep_cnt] = i;
        rep_cnt++;
      end
    end
    pbtn_db = 6'h00;
    cyc();
    chk("b1_release", btn_release, 6'h02);
    chk("b1_no_rep_at_release", btn_repeat, 6'h00);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (btn_repeat[1]) extra++;
    end
    chk("b1_no_rep_after", extra, 0);
    chk("b1_rep_count", rep_cnt, 3);
    chk("b1_first_rep_window", (rep_pos[0] >= 12 && rep_pos[0] <= 16), 1'b1);
    chk("b1_rep_gap1", rep_pos[1] - rep_pos[0], 10);
    chk("b1_rep_gap2", rep_pos[2] - rep_pos[1], 10);

    // Reset button never repeats.
    pbtn_db = 6'h01;
    acc = 0;
    for (int i = 1; i <= 50; i++) begin
      cyc();
      if (i == 1) chk("b0_press", btn_press, 6'h01);
      if (btn_repeat[0]) acc++;
    end
    pbtn_db = 6'h00;
    cyc();
    chk("b0_release", btn_release, 6'h01);
    chk("b0_no_repeat", acc, 0);

    // Release lands on the edge of button 3's second repeat.
    pbtn_db = 6'h08;
    r1 = 0;
    for (int i = 1; i <= 20 && r1 == 0; i++) begin
      cyc();
      if (btn_repeat[3]) r1 = i;
    end
    chk("b3_first_rep_seen", (r1 != 0), 1'b1);
    for (int i = 0; i < 9; i++) cyc();
    pbtn_db = 6'h00;
    cyc();
    chk("col_release", btn_release, 6'h08);
    chk("col_repeat", btn_repeat, 6'h00);

    // Switch changes without ack.
    swtch_db = 16'h0000;
    cyc();
    chk("sw0_changed", sw_changed, 1'b1);
    chk("sw0_pending", sw_event_pending, 1'b1);
    sw_ack = 1'b1;
    cyc();
    sw_ack = 1'b0;
    chk("sw0_ack_clear", sw_event_pending, 1'b0);
    swtch_db = 16'h0001;
    cyc();
    chk("sw1_changed", sw_changed, 1'b1);
    chk("sw1_snapshot", sw_snapshot, 16'h0001);
    cyc();
    chk("sw1_changed_single", sw_changed, 1'b0);
    swtch_db = 16'h0003;
    cyc();
    chk("sw3_changed", sw_changed, 1'b1);
    chk("sw3_snapshot", sw_snapshot, 16'h0003);
    chk("sw3_pending", sw_event_pending, 1'b1);
    cyc();
    chk("sw3_changed_single", sw_changed, 1'b0);
    sw_ack = 1'b1;
    cyc();
    sw_ack = 1'b0;
    chk("sw3_ack_clear", sw_event_pending, 1'b0);
    sw_ack = 1'b1;
    cyc();
    sw_ack = 1'b0;
    chk("idle_ack_pending", sw_event_pending, 1'b0);
    chk("idle_ack_changed", sw_changed, 1'b0);
    chk("idle_ack_snapshot", sw_snapshot, 16'h0003);

    // Change and ack together: the change wins.
    swtch_db = 16'h0007;
    cyc();
    chk("sw7_pending", sw_event_pending, 1'b1);
    swtch_db = 16'h8000;
    sw_ack = 1'b1;
    cyc();
    sw_ack = 1'b0;
    chk("swack_pending", sw_event_pending, 1'b1);
    chk("swack_snapshot", sw_snapshot, 16'h8000);
    chk("swack_changed", sw_changed, 1'b1);

    // Async reset while button 4 is repeating.
    pbtn_db = 6'h10;
    r1 = 0;
    for (int i = 1; i <= 25 && r1 == 0; i++) begin
      cyc();
      if (btn_repeat[4]) r1 = i;
    end
    chk("b4_rep_seen", (r1 != 0), 1'b1);
    chk("b4_pending_before", sw_event_pending, 1'b1);
    #1 sysreset_n = 1'b0;
    #1;
    chk("arst_press", btn_press, 6'h00);
    chk("arst_release", btn_release, 6'h00);
    chk("arst_repeat", btn_repeat, 6'h00);
    chk("arst_changed", sw_changed, 1'b0);
    chk("arst_snapshot", sw_snapshot, 16'h0000);
    chk("arst_pending", sw_event_pending, 1'b0);
    cyc();
    cyc();
    sysreset_n = 1'b1;
    cyc();
    chk("reprime_press", btn_press, 6'h00);
    chk("reprime_changed", sw_changed, 1'b0);
    chk("reprime_snapshot", sw_snapshot, 16'h8000);
    cyc();
    chk("reprime_press2", btn_press, 6'h00);
    pbtn_db = 6'h00;
    cyc();
    chk("reprime_release", btn_release, 6'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
